multicycle_control: RTL and testbench
=====================================

# multicycle_control

Multi-cycle control unit for the MIPS processor. It replaces the single-cycle opcode decoder with a state machine that sequences fetch, decode, execute, memory and write-back over several cycles, sharing one ALU and one memory port. It waits on a memory-ready handshake, bounded by a timeout, and supports the existing instruction set: R-type, JR, ADDI, ANDI, ORI, LUI, BEQ, BNE, J, JAL, LW and SW. It sits between the instruction register and the datapath muxes and enables.

## Interface
Parameters:
- MEM_TIMEOUT, default 15: maximum number of cycles spent waiting on mem_ready before entering FAULT; legal range 1..255.
- ALUOP_W, default 3: width of alu_op.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- op  in  6  instruction register [31:26].
- funct  in  6  instruction register [5:0].
- mem_ready  in  1  memory completed the current read or write this cycle.
- mem_read, mem_write  out  1  memory strobes, held until mem_ready.
- iord  out  1  memory address source: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_eq, pc_write_ne  out  1  conditional PC load on zero / not-zero.
- pc_source  out  2  next-PC source: 00 = ALU, 01 = ALUOut, 10 = jump target, 11 = register A.
- reg_write  out  1  register file write enable.
- reg_dst  out  1  write-register select: 1 = rd, 0 = rt.
- mem_to_reg  out  1  write-back data select: 1 = MDR, 0 = ALUOut.
- jal  out  1  force write register to 31 and write data to PC.
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A.
- alu_src_b  out  2  ALU B input: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = shifted immediate.
- alu_op  out  ALUOP_W  ALU operation code.
- fault  out  1  sticky illegal-opcode or timeout flag.
- state  out  4  current state, for debug.

## Operation
State encodings:
- FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_RD = 3, MEM_WB = 4, MEM_WR = 5
- EXEC_R = 6, R_WB = 7, EXEC_I = 8, I_WB = 9
- BRANCH = 10, JUMP = 11, JAL_S = 12, JR_S = 13, FAULT = 14

ALU op codes: ADD = 100, AND = 011, OR = 101, LUI = 001, SUB_EQ = 010, SUB_NE = 110, R-type = 111.

Per-state behaviour:
- **FETCH**
  - Drives mem_read = 1, iord = 0, alu_src_a = 0, alu_src_b = 01, alu_op = ADD.
  - When mem_ready = 1 in the same cycle, also asserts ir_write = 1 and pc_write = 1 with pc_source = 00, then moves to DECODE.
- **DECODE**
  - Drives alu_src_a = 0, alu_src_b = 11, alu_op = ADD, which precomputes the branch target.
  - Dispatch by op:
    - 0 with funct = 0x08 goes to JR_S; any other funct goes to EXEC_R.
    - 0x23 and 0x2B go to MEM_ADDR.
    - 0x08, 0x0C, 0x0D and 0x0F go to EXEC_I.
    - 0x04 and 0x05 go to BRANCH.
    - 0x02 goes to JUMP; 0x03 goes to JAL_S.
    - Any other opcode goes to FAULT.
- **MEM_ADDR**: alu_src_a = 1, alu_src_b = 10, alu_op = ADD. Goes to MEM_RD for LW, MEM_WR for SW.
- **MEM_RD**: mem_read = 1, iord = 1. Waits for mem_ready, then goes to MEM_WB.
- **MEM_WB**: reg_write = 1, reg_dst = 0, mem_to_reg = 1. Goes to FETCH.
- **MEM_WR**: mem_write = 1, iord = 1. Waits for mem_ready, then goes to FETCH.
- **EXEC_R**: alu_src_a = 1, alu_src_b = 00, alu_op = 111. Goes to R_WB.
- **R_WB**: reg_write = 1, reg_dst = 1, mem_to_reg = 0. Goes to FETCH.
- **EXEC_I**
  - alu_src_a = 1, alu_src_b = 10.
  - alu_op = ADD for ADDI, AND for ANDI, OR for ORI, LUI for LUI.
  - Goes to I_WB.
- **I_WB**: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Goes to FETCH.
- **BRANCH**
  - alu_src_a = 1, alu_src_b = 00, pc_source = 01.
  - BEQ: pc_write_eq = 1, alu_op = 010. BNE: pc_write_ne = 1, alu_op = 110.
  - Goes to FETCH.
- **JUMP**: pc_write = 1, pc_source = 10. Goes to FETCH.
- **JAL_S**: pc_write = 1, pc_source = 10, reg_write = 1, jal = 1. The PC already holds PC+4 and is written to $31. Goes to FETCH.
- **JR_S**: pc_write = 1, pc_source = 11. Goes to FETCH.
- **FAULT**: fault = 1, all strobes 0. Stays in FAULT until reset.

Defaults:
- Any signal not listed for a state is 0.
- alu_op defaults to ADD.

Wait counter:
- Counts cycles spent in FETCH, MEM_RD and MEM_WR while mem_ready = 0.
- Clears on every state change.
- If the counter reaches MEM_TIMEOUT with mem_ready still 0, the next state is FAULT.
- If mem_ready and the timeout occur in the same cycle, mem_ready wins.

## Timing
Reset:
- reset = 1 forces state = FETCH, clears the wait counter and clears fault immediately (asynchronous).
- Output values during and right after reset are the FETCH values with mem_ready = 0: mem_read = 1, alu_src_b = 01, alu_op = 100, all other outputs 0, state = 0.
- Reset asserted mid-instruction abandons the instruction; no partial write strobe is issued after the reset edge.

Output timing:
- Outputs are combinational from state, op and funct.
- In FETCH only, ir_write and pc_write also depend on mem_ready (Mealy).
- All state transitions happen on the clk rising edge.

Cycles per instruction with zero memory wait:

| Instruction | Cycles |
|---|---|
| R-type, ADDI, ANDI, ORI, LUI | 4 |
| LW | 5 |
| SW | 4 |
| BEQ, BNE, J, JAL, JR | 3 |

Each cycle spent waiting on mem_ready adds one cycle.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode and funct constants;
  - state encodings;
  - ALU op codes;
  - pc_source and alu_src_b encodings.
- Sub-module mem_wait_timer (parameter MEM_TIMEOUT):
  - inputs: clk, reset, clear, waiting;
  - output: expired.
- The state register and next-state/output decode stay in multicycle_control.

## Test plan
- **ADD, zero wait:** op = 0, funct = 0x20, mem_ready always 1.
  - Expected state sequence: 0, 1, 6, 7, 0.
  - reg_write = 1 with reg_dst = 1 in cycle 4 only; alu_op = 111 in EXEC_R.
- **LW with wait:** op = 0x23; mem_ready held low 3 cycles in MEM_RD.
  - Expected sequence: 0, 1, 2, 3, 3, 3, 3, 4, 0.
  - mem_read and iord = 1 throughout MEM_RD; mem_to_reg = 1 in MEM_WB.
- **BNE:** op = 0x05.
  - Expected sequence: 0, 1, 10, 0.
  - pc_write_ne = 1, alu_op = 110, pc_source = 01 in BRANCH; pc_write_eq = 0.
- **JAL and JR:**
  - op = 0x03: jal = 1, reg_write = 1, pc_write = 1, pc_source = 10 in state 12.
  - op = 0, funct = 0x08: state 13 with pc_source = 11 and reg_write = 0.
- **Faults:**
  - op = 0x3F goes DECODE then FAULT; fault = 1 stays set for 20 cycles.
  - With MEM_TIMEOUT = 4 and mem_ready held 0 in FETCH, FAULT is entered after exactly 4 wait cycles.
- **Reset mid-instruction:** assert reset asynchronously during MEM_WR.
  - state = 0 and mem_write = 0 immediately.
  - fault cleared.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funct codes,
// FSM states, ALU operation codes and datapath mux selects.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FUNCT_JR = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEM_ADDR = 4'd2,
    S_MEM_RD   = 4'd3,
    S_MEM_WB   = 4'd4,
    S_MEM_WR   = 4'd5,
    S_EXEC_R   = 4'd6,
    S_R_WB     = 4'd7,
    S_EXEC_I   = 4'd8,
    S_I_WB     = 4'd9,
    S_BRANCH   = 4'd10,
    S_JUMP     = 4'd11,
    S_JAL      = 4'd12,
    S_JR       = 4'd13,
    S_FAULT    = 4'd14
  } state_e;

  localparam logic [2:0] ALU_ADD    = 3'b100;
  localparam logic [2:0] ALU_AND    = 3'b011;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_LUI    = 3'b001;
  localparam logic [2:0] ALU_SUB_EQ = 3'b010;
  localparam logic [2:0] ALU_SUB_NE = 3'b110;
  localparam logic [2:0] ALU_RTYPE  = 3'b111;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // States that hold a memory strobe and wait on mem_ready.
  function automatic logic is_wait_state(state_e s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles spent waiting on memory and flags the cycle in
// which the wait budget is exhausted.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  logic [7:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear)        count_d = '0;
    else if (waiting) count_d = count_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  // This is the MEM_TIMEOUT-th stalled cycle; a ready memory never expires.
  assign expired = waiting && (count_q == 8'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back
// over a shared ALU and memory port, with a bounded memory-ready wait.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int ALUOP_W     = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         op,
  input  logic [5:0]         funct,
  input  logic               mem_ready,
  output logic               mem_read,
  output logic               mem_write,
  output logic               iord,
  output logic               ir_write,
  output logic               pc_write,
  output logic               pc_write_eq,
  output logic               pc_write_ne,
  output logic [1:0]         pc_source,
  output logic               reg_write,
  output logic               reg_dst,
  output logic               mem_to_reg,
  output logic               jal,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               fault,
  output logic [3:0]         state
);

  state_e     state_q, state_d;
  logic [2:0] alu_code;
  logic       wait_expired;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_d != state_q),
    .waiting (is_wait_state(state_q) && !mem_ready),
    .expired (wait_expired)
  );

  always_comb begin
    // NOTE: every output and state_d gets a default first, so no path through
    // the case below can leave a value unassigned and infer a latch.
    state_d     = state_q;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    iord        = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    pc_write_eq = 1'b0;
    pc_write_ne = 1'b0;
    pc_source   = PCSRC_ALU;
    reg_write   = 1'b0;
    reg_dst     = 1'b0;
    mem_to_reg  = 1'b0;
    jal         = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = SRCB_REGB;
    alu_code    = ALU_ADD;
    fault       = 1'b0;

    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_expired) begin
          state_d = S_FAULT;
        end
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH;
        case (op)
          OP_RTYPE:                        state_d = (funct == FUNCT_JR) ? S_JR : S_EXEC_R;
          OP_LW, OP_SW:                    state_d = S_MEM_ADDR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI: state_d = S_EXEC_I;
          OP_BEQ, OP_BNE:                  state_d = S_BRANCH;
          OP_J:                            state_d = S_JUMP;
          OP_JAL:                          state_d = S_JAL;
          default:                         state_d = S_FAULT;
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready)         state_d = S_MEM_WB;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready)         state_d = S_FETCH;
        else if (wait_expired) state_d = S_FAULT;
      end
      S_EXEC_R: begin
        alu_src_a = 1'b1;
        alu_code  = ALU_RTYPE;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        state_d   = S_FETCH;
      end
      S_EXEC_I: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        case (op)
          OP_ANDI: alu_code = ALU_AND;
          OP_ORI:  alu_code = ALU_OR;
          OP_LUI:  alu_code = ALU_LUI;
          default: alu_code = ALU_ADD;
        endcase
        state_d = S_I_WB;
      end
      S_I_WB: begin
        reg_write = 1'b1;
        state_d   = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a = 1'b1;
        pc_source = PCSRC_ALUOUT;
        if (op == OP_BNE) begin
          pc_write_ne = 1'b1;
          alu_code    = ALU_SUB_NE;
        end else begin
          pc_write_eq = 1'b1;
          alu_code    = ALU_SUB_EQ;
        end
        state_d = S_FETCH;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        state_d   = S_FETCH;
      end
      S_JAL: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        reg_write = 1'b1;
        jal       = 1'b1;
        state_d   = S_FETCH;
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_REGA;
        state_d   = S_FETCH;
      end
      S_FAULT: begin
        fault = 1'b1;
      end
      default: begin
        state_d = S_FAULT;
      end
    endcase
  end

  assign alu_op = ALUOP_W'(alu_code);
  assign state  = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench: each instruction is expanded into its expected
// per-cycle state path, and the full control word is compared every cycle.
module tb_multicycle_control;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       mem_ready;
  logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_eq, pc_write_ne;
  logic [1:0] pc_source;
  logic       reg_write, reg_dst, mem_to_reg, jal, alu_src_a;
  logic [1:0] alu_src_b;
  logic [2:0] alu_op;
  logic       fault;
  logic [3:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       mem_read, mem_write, iord, ir_write, pc_write, pc_write_eq, pc_write_ne;
    logic [1:0] pc_source;
    logic       reg_write, reg_dst, mem_to_reg, jal, alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic       fault;
    logic [3:0] state;
  } cw_t;

  typedef struct {
    int st;
    bit rdy;
  } step_t;

  step_t path[$];
  cw_t   act;

  always #5 clk = ~clk;

  multicycle_control #(.MEM_TIMEOUT(T), .ALUOP_W(3)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .mem_ready(mem_ready),
    .mem_read(mem_read), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
    .pc_write(pc_write), .pc_write_eq(pc_write_eq), .pc_write_ne(pc_write_ne),
    .pc_source(pc_source), .reg_write(reg_write), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .jal(jal), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .fault(fault), .state(state)
  );

  assign act = {mem_read, mem_write, iord, ir_write, pc_write, pc_write_eq, pc_write_ne,
                pc_source, reg_write, reg_dst, mem_to_reg, jal, alu_src_a, alu_src_b,
                alu_op, fault, state};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word the datapath should see for a state (numbered as in the state table).
  function automatic cw_t expect_cw(int st, bit rdy, logic [5:0] o);
    cw_t c;
    c = '0;
    c.alu_op = 3'b100;
    c.state  = 4'(st);
    case (st)
      0:  begin c.mem_read = 1; c.alu_src_b = 2'b01;
                if (rdy) begin c.ir_write = 1; c.pc_write = 1; end end
      1:  c.alu_src_b = 2'b11;
      2:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10; end
      3:  begin c.mem_read = 1; c.iord = 1; end
      4:  begin c.reg_write = 1; c.mem_to_reg = 1; end
      5:  begin c.mem_write = 1; c.iord = 1; end
      6:  begin c.alu_src_a = 1; c.alu_op = 3'b111; end
      7:  begin c.reg_write = 1; c.reg_dst = 1; end
      8:  begin c.alu_src_a = 1; c.alu_src_b = 2'b10;
                c.alu_op = (o == 6'h0C) ? 3'b011 : (o == 6'h0D) ? 3'b101 :
                           (o == 6'h0F) ? 3'b001 : 3'b100; end
      9:  c.reg_write = 1;
      10: begin c.alu_src_a = 1; c.pc_source = 2'b01;
                if (o == 6'h05) begin c.pc_write_ne = 1; c.alu_op = 3'b110; end
                else            begin c.pc_write_eq = 1; c.alu_op = 3'b010; end end
      11: begin c.pc_write = 1; c.pc_source = 2'b10; end
      12: begin c.pc_write = 1; c.pc_source = 2'b10; c.reg_write = 1; c.jal = 1; end
      13: begin c.pc_write = 1; c.pc_source = 2'b11; end
      14: c.fault = 1;
      default: ;
    endcase
    return c;
  endfunction

  function automatic bit is_legal(logic [5:0] o);
    return o inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
  endfunction

  task automatic push(int st, bit rdy);
    step_t s;
    s.st = st;
    s.rdy = rdy;
    path.push_back(s);
  endtask

  // A memory phase of w stalled cycles; w >= T runs out the budget into FAULT.
  task automatic add_mem(int st, int w, output bit faulted);
    faulted = 0;
    if (w >= T) begin
      repeat (T) push(st, 0);
      push(14, 1'($urandom_range(0, 1)));
      faulted = 1;
    end else begin
      repeat (w) push(st, 0);
      push(st, 1);
    end
  endtask

  task automatic build_path(logic [5:0] o, logic [5:0] f, int wf, int wm);
    bit flt;
    path.delete();
    add_mem(0, wf, flt);
    if (flt) return;
    push(1, 1'($urandom_range(0, 1)));
    if (o == 6'h00) begin
      if (f == 6'h08) push(13, 1'($urandom_range(0, 1)));
      else begin push(6, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
    end else if (o == 6'h23) begin
      push(2, 1'($urandom_range(0, 1)));
      add_mem(3, wm, flt);
      if (!flt) push(4, 1'($urandom_range(0, 1)));
    end else if (o == 6'h2B) begin
      push(2, 1'($urandom_range(0, 1)));
      add_mem(5, wm, flt);
    end else if (o inside {6'h08, 6'h0C, 6'h0D, 6'h0F}) begin
      push(8, 1'($urandom_range(0, 1))); push(9, 1'($urandom_range(0, 1)));
    end else if (o inside {6'h04, 6'h05}) push(10, 1'($urandom_range(0, 1)));
    else if (o == 6'h02) push(11, 1'($urandom_range(0, 1)));
    else if (o == 6'h03) push(12, 1'($urandom_range(0, 1)));
    else push(14, 1'($urandom_range(0, 1)));
  endtask

  // Entered and left at a falling edge; reset is raised mid-cycle, asynchronously.
  task automatic do_reset(input string tag);
    #2;
    reset = 1'b1;
    mem_ready = 1'b0;
    #1 check({tag, "_async"}, 32'(act), 32'(expect_cw(0, 0, op)));
    @(negedge clk);
    check({tag, "_held"}, 32'(act), 32'(expect_cw(0, 0, op)));
    reset = 1'b0;
  endtask

  // Plays the current path; stop_st >= 0 resets right after that state's first cycle.
  task automatic run_path(input string tag, logic [5:0] o, logic [5:0] f, int hold, int stop_st);
    for (int i = 0; i < path.size(); i++) begin
      if (i == 0) begin op = o; funct = f; end
      mem_ready = path[i].rdy;
      #1 check(tag, 32'(act), 32'(expect_cw(path[i].st, path[i].rdy, o)));
      if (path[i].st == stop_st) begin
        do_reset({tag, "_midrst"});
        return;
      end
      @(negedge clk);
    end
    if (path.size() > 0 && path[path.size()-1].st == 14) begin
      for (int k = 0; k < hold; k++) begin
        mem_ready = 1'($urandom_range(0, 1));
        #1 check({tag, "_fault_hold"}, 32'(act), 32'(expect_cw(14, 0, o)));
        @(negedge clk);
      end
      do_reset({tag, "_fault_rst"});
    end
  endtask

  task automatic run_instr(input string tag, logic [5:0] o, logic [5:0] f, int wf, int wm, int hold);
    build_path(o, f, wf, wm);
    run_path(tag, o, f, hold, -1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    logic [5:0] legal_ops[12];
    logic [5:0] o, f;
    int wf, wm;

    legal_ops = '{6'h00, 6'h00, 6'h02, 6'h03, 6'h04, 6'h05,
                  6'h08, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
    reset = 1'b1; mem_ready = 1'b0; op = '0; funct = '0;
    #1 check("reset_state", 32'(act), 32'(expect_cw(0, 0, 6'h00)));
    @(negedge clk);
    reset = 1'b0;

    run_instr("add_nowait", 6'h00, 6'h20, 0, 0, 0);
    run_instr("lw_wait3",   6'h23, 6'h00, 0, 3, 0);
    run_instr("bne",        6'h05, 6'h11, 0, 0, 0);
    run_instr("beq",        6'h04, 6'h00, 1, 0, 0);
    run_instr("jal",        6'h03, 6'h00, 0, 0, 0);
    run_instr("jr",         6'h00, 6'h08, 0, 0, 0);
    run_instr("sw_wait",    6'h2B, 6'h00, 2, T - 1, 0);
    run_instr("lui",        6'h0F, 6'h00, 0, 0, 0);
    run_instr("illegal",    6'h3F, 6'h00, 0, 0, 20);
    run_instr("fetch_tmo",  6'h00, 6'h20, T, 0, 3);
    run_instr("lw_tmo",     6'h23, 6'h00, 0, T, 3);

    build_path(6'h2B, 6'h00, 0, 3);
    run_path("sw_reset", 6'h2B, 6'h00, 0, 5);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 14) == 0) begin
        do o = 6'($urandom); while (is_legal(o));
      end else begin
        o = legal_ops[$urandom_range(0, 11)];
      end
      f  = ($urandom_range(0, 3) == 0) ? 6'h08 : 6'($urandom);
      wf = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, T - 1);
      wm = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, T - 1);
      run_instr("rand", o, f, wf, wm, $urandom_range(1, 4));
    end

    mem_ready = 1'b0;
    #1 check("final_fetch", 32'(act), 32'(expect_cw(0, 0, op)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
